// File: rtl/mp_add_seq_pkg.sv
// Shared definitions for the word-serial multi-precision adder.
package mp_add_seq_pkg;

  localparam int ADD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the word index: enough bits to count to nWords-1, never narrower than 1.
  function automatic int idxWidth(input int nWords);
    return (nWords > 1) ? $clog2(nWords) : 1;
  endfunction

endpackage

// File: rtl/mp_add_seq_csa.sv
// 32-bit square-root carry-select adder: blocks of 2,3,4,5,6,7,5 bits, each
// evaluated for both incoming carries and then selected by the real carry.
module SquareRootCSA
  import mp_add_seq_pkg::*;
(
  output logic [ADD_W:0]   sout,
  input  logic [ADD_W-1:0] in1,
  input  logic [ADD_W-1:0] in2,
  input  logic             c0
);

  // Bit positions where a new carry-select block begins (0,2,5,9,14,20,27).
  localparam logic [ADD_W-1:0] BLOCK_START = 32'h0810_4225;

  // Ripple each block twice (carry 0 and carry 1), then pick with the block carry-in.
  always_comb begin
    logic blockCin;
    logic c0Chain;
    logic c1Chain;
    logic s0;
    logic s1;
    logic p;
    sout     = '0;
    blockCin = c0;
    c0Chain  = 1'b0;
    c1Chain  = 1'b1;
    s0       = 1'b0;
    s1       = 1'b0;
    p        = 1'b0;
    for (int i = 0; i < ADD_W; i++) begin
      if (i > 0 && BLOCK_START[i]) begin
        blockCin = blockCin ? c1Chain : c0Chain;
        c0Chain  = 1'b0;
        c1Chain  = 1'b1;
      end
      p       = in1[i] ^ in2[i];
      s0      = p ^ c0Chain;
      s1      = p ^ c1Chain;
      c0Chain = (in1[i] & in2[i]) | (c0Chain & p);
      c1Chain = (in1[i] & in2[i]) | (c1Chain & p);
      sout[i] = blockCin ? s1 : s0;
    end
    sout[ADD_W] = blockCin ? c1Chain : c0Chain;
  end

endmodule

// File: rtl/mp_add_seq.sv
// Word-serial adder: in1+in2+c0 at 32*NWORDS-bit precision, one 32-bit word per
// cycle through a single SquareRootCSA, least-significant word first.
module mp_add_seq
  import mp_add_seq_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADD_W*NWORDS-1:0] in1,
  input  logic [ADD_W*NWORDS-1:0] in2,
  input  logic                   c0,
  input  logic                   start_valid,
  output logic                   start_ready,
  output logic [ADD_W*NWORDS:0]  sout,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   busy
);

  localparam int W     = ADD_W * NWORDS;
  localparam int IDX_W = idxWidth(NWORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     opA_q, opA_d;
  logic [W-1:0]     opB_q, opB_d;
  logic [W:0]       sum_q, sum_d;

  logic [ADD_W-1:0] csaA;
  logic [ADD_W-1:0] csaB;
  logic [ADD_W:0]   csaSum;
  int               wordOff;

  assign wordOff = int'(idx_q) * ADD_W;
  assign csaA    = opA_q[wordOff +: ADD_W];
  assign csaB    = opB_q[wordOff +: ADD_W];

  SquareRootCSA uCsa (
    .sout (csaSum),
    .in1  (csaA),
    .in2  (csaB),
    .c0   (carry_q)
  );

  // State, operand, carry and result registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      opA_q   <= '0;
      opB_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      sum_q   <= sum_d;
    end
  end

  // Next-state logic: latch at start, one word per ADD cycle, hold result in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          opA_d   = in1;
          opB_d   = in2;
          carry_d = c0;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[wordOff +: ADD_W] = csaSum[ADD_W-1:0];
        carry_d                 = csaSum[ADD_W];
        if (idx_q == LAST_IDX) begin
          sum_d[W] = csaSum[ADD_W];
          state_d  = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded straight from the state register.
  always_comb begin
    start_ready = (state_q == IDLE);
    res_valid   = (state_q == DONE);
    busy        = (state_q != IDLE);
    sout        = sum_q;
  end

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq against a plain-arithmetic reference sum.
module tb_mp_add_seq;

  localparam int NWORDS = 4;
  localparam int W      = 32 * NWORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         c0;
  logic         start_valid;
  logic         start_ready;
  logic [W:0]   sout;
  logic         res_valid;
  logic         res_ready;
  logic         busy;

  int assertCount = 0;
  int failCount   = 0;

  mp_add_seq #(.NWORDS(NWORDS)) dut (
    .clk         (clk),
    .rst         (rst),
    .in1         (in1),
    .in2         (in2),
    .c0          (c0),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .sout        (sout),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .busy        (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [W-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: full-precision sum with plain arithmetic.
  function automatic logic [W:0] refSum(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic c);
    logic [W:0] r;
    r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one operation from IDLE, scramble inputs during ADD, return edges until res_valid.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                               output int lat);
    checkOutput("start_ready_idle", 256'(start_ready), 256'(1));
    in1         = a;
    in2         = b;
    c0          = c;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    in1         = rand128();
    in2         = rand128();
    c0          = ~c;
    lat         = 0;
    while (!res_valid && lat < 20) begin
      tick();
      lat++;
      in1 = rand128();
      in2 = rand128();
    end
  endtask

  task automatic releaseResult(input logic [W:0] exp);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checkOutput("release_res_valid", 256'(res_valid), 256'(0));
    checkOutput("release_start_ready", 256'(start_ready), 256'(1));
    checkOutput("idle_sout_retained", 256'(sout), 256'(exp));
  endtask

  task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic [W:0] exp);
    int lat;
    applyStimulus(a, b, c, lat);
    checkOutput({tag, "_latency"}, 256'(lat), 256'(NWORDS));
    checkOutput({tag, "_sout"}, 256'(sout), 256'(exp));
    releaseResult(exp);
  endtask

  logic [W:0] expQ[$];

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W:0]   exp;
    int           lat;
    int           cyc;
    int           hsCount;
    int           resCount;
    int           lastHs;

    rst         = 1'b1;
    in1         = '0;
    in2         = '0;
    c0          = 1'b0;
    start_valid = 1'b0;
    res_ready   = 1'b0;

    // Reset state.
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_sout", 256'(sout), 256'(0));
    checkOutput("reset_res_valid", 256'(res_valid), 256'(0));
    checkOutput("reset_busy", 256'(busy), 256'(0));
    checkOutput("reset_start_ready", 256'(start_ready), 256'(1));

    // All-ones plus carry-in ripples through every word.
    runOp("allones", {W{1'b1}}, '0, 1'b1, {1'b1, {W{1'b0}}});

    // Carry crossing one word boundary.
    runOp("wordcarry", 128'h00000000_00000000_00000001_FFFFFFFF, 128'h1, 1'b0,
          129'h0_00000000_00000000_00000002_00000000);

    // Assorted directed and random operands.
    runOp("zero", '0, '0, 1'b0, '0);
    runOp("maxmax", {W{1'b1}}, {W{1'b1}}, 1'b1, refSum({W{1'b1}}, {W{1'b1}}, 1'b1));
    for (int k = 0; k < 6; k++) begin
      a = rand128();
      b = rand128();
      c = 1'($urandom_range(0, 1));
      runOp("random", a, b, c, refSum(a, b, c));
    end

    // Result held for ten cycles with res_ready low.
    a   = rand128();
    b   = rand128();
    exp = refSum(a, b, 1'b1);
    applyStimulus(a, b, 1'b1, lat);
    checkOutput("hold_latency", 256'(lat), 256'(NWORDS));
    for (int k = 0; k < 10; k++) begin
      checkOutput("hold_sout", 256'(sout), 256'(exp));
      checkOutput("hold_res_valid", 256'(res_valid), 256'(1));
      checkOutput("hold_start_ready", 256'(start_ready), 256'(0));
      checkOutput("hold_busy", 256'(busy), 256'(1));
      tick();
    end
    releaseResult(exp);

    // Reset after two ADD cycles discards the operation.
    in1         = rand128();
    in2         = rand128();
    c0          = 1'b1;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_res_valid", 256'(res_valid), 256'(0));
    checkOutput("abort_start_ready", 256'(start_ready), 256'(1));
    checkOutput("abort_sout", 256'(sout), 256'(0));
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (res_valid) lat++;
    end
    checkOutput("abort_no_result", 256'(lat), 256'(0));

    // Back-to-back traffic with both handshakes tied high.
    cyc       = 0;
    hsCount   = 0;
    resCount  = 0;
    lastHs    = -1;
    res_ready = 1'b1;
    while (resCount < 1000 && cyc < 7000) begin
      a           = rand128();
      b           = rand128();
      c           = 1'($urandom_range(0, 1));
      in1         = a;
      in2         = b;
      c0          = c;
      start_valid = (hsCount < 1000);
      if (start_ready && hsCount < 1000) begin
        expQ.push_back(refSum(a, b, c));
        if (lastHs >= 0) checkOutput("stream_spacing", 256'(cyc - lastHs), 256'(NWORDS + 2));
        lastHs = cyc;
        hsCount++;
      end
      tick();
      cyc++;
      if (res_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("stream_unexpected_result", 256'(1), 256'(0));
        end else begin
          checkOutput("stream_sout", 256'(sout), 256'(expQ.pop_front()));
        end
        resCount++;
      end
    end
    start_valid = 1'b0;
    res_ready   = 1'b0;
    checkOutput("stream_result_count", 256'(resCount), 256'(1000));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mp_add_seq.md
MP_ADD_SEQ -- requirements
Module: mp_add_seq

Interface
REQ-001 The block SHALL have parameter NWORDS, default 4, meaning the number of 32-bit words per operand; operand width is 32*NWORDS.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port in1  input  32*NWORDS  operand A, sampled only at the start handshake.
REQ-005 The block SHALL have port in2  input  32*NWORDS  operand B, sampled only at the start handshake.
REQ-006 The block SHALL have port c0  input  1  carry-in, sampled only at the start handshake.
REQ-007 The block SHALL have port start_valid  input  1  requester presents an operation.
REQ-008 The block SHALL have port start_ready  output  1  block can accept an operation.
REQ-009 The block SHALL have port sout  output  32*NWORDS+1  registered result {carry-out, sum}.
REQ-010 The block SHALL have port res_valid  output  1  sout holds a completed result.
REQ-011 The block SHALL have port res_ready  input  1  consumer accepts the result.
REQ-012 The block SHALL have port busy  output  1  high in ADD or DONE.

Function
REQ-013 The block SHALL compute in1+in2+c0 at full precision by issuing one 32-bit word per cycle, least-significant word first, through a single SquareRootCSA instance, chaining the carry.
REQ-014 The FSM SHALL have states IDLE, ADD and DONE.
REQ-015 The block SHALL drive start_ready=1 only in IDLE; a start handshake is start_valid&&start_ready at a rising edge.
REQ-016 On a start handshake the block SHALL latch in1, in2 and c0, clear the word index to 0, load the carry register with c0, and enter ADD.
REQ-017 In ADD, in each cycle the block SHALL drive word[idx] of A, word[idx] of B and the carry register into the adder, write adder sout[31:0] into word idx of the result register, load the carry register with adder sout[32], and increment idx.
REQ-018 When idx==NWORDS-1 in ADD, the block SHALL also write the final carry into sout[32*NWORDS] and enter DONE.
REQ-019 The latency SHALL be fixed: res_valid rises exactly NWORDS clock edges after the start handshake edge, regardless of the data.
REQ-020 In DONE the block SHALL hold res_valid=1 and sout stable until res_ready=1 at an edge, then return to IDLE.
REQ-021 The block SHALL NOT accept a start in the same cycle as the result handshake; the peak throughput is one operation per NWORDS+2 cycles.
REQ-022 The block SHALL ignore start_valid and input changes while in ADD or DONE.
REQ-023 The index SHALL be ceil(log2(NWORDS)) bits wide, minimum 1, and SHALL NOT wrap beyond NWORDS-1.
REQ-024 sout SHALL retain its last value in IDLE until the next result overwrites it word by word.

Reset
REQ-025 While rst=1 at an edge, the block SHALL enter IDLE with sout=0, res_valid=0, busy=0, idx=0 and carry=0; start_ready becomes 1 after the edge.
REQ-026 Reset SHALL take priority over every handshake; a reset during ADD or DONE SHALL discard the operation with no res_valid pulse.

Structure
REQ-027 A shared package SHALL hold the adder width constant ADD_W=32 and the FSM state enum.
REQ-028 The block SHALL instantiate exactly one sub-module, SquareRootCSA (ports sout, in1, in2, c0), used as the combinational datapath, with no other adder logic.

Verification
REQ-029 The bench SHALL cover this scenario: in1=all-ones (128-bit), in2=0, c0=1 -> sout=1_00000000_00000000_00000000_00000000 hex, with res_valid exactly 4 edges after the handshake.
REQ-030 The bench SHALL cover this scenario: in1=0x00000000_00000000_00000001_FFFFFFFF, in2=0x1, c0=0 -> sout=0x0_00000000_00000000_00000002_00000000.
REQ-031 The bench SHALL cover this scenario: res_ready held 0 for 10 cycles in DONE -> sout and res_valid stable, start_ready=0 and busy=1 throughout.
REQ-032 The bench SHALL cover this scenario: rst=1 for one cycle after 2 ADD cycles -> next cycle res_valid=0, start_ready=1, sout=0, and no later result.
REQ-033 The bench SHALL cover this scenario: start_valid and res_ready tied to 1 with 1000 random operands -> every sout matches a 129-bit reference sum, with handshakes spaced exactly 6 cycles apart.
REQ-034 The bench SHALL cover this scenario: in1 and in2 changed during ADD -> the result reflects the operands latched at the handshake only.
